// File: rtl/bp_cfg_stream_loader_pkg.sv
// Shared state encoding, cfg bus beat layout and freeze data values for the cfg stream loader.
// Pure declarations: no latency, no backpressure.
package bp_cfg_stream_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_LOAD,
    S_UNFREEZE,
    S_DONE
  } bp_cfg_loader_state_e;

  localparam int cfg_core_width_gp = 8;
  localparam int cfg_addr_width_gp = 16;
  localparam int cfg_data_width_gp = 32;

  typedef struct packed {
    logic [cfg_core_width_gp-1:0] core;
    logic [cfg_addr_width_gp-1:0] addr;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_beat_s;

  localparam logic cfg_freeze_data_gp   = 1'b1;
  localparam logic cfg_unfreeze_data_gp = 1'b0;

endpackage

// File: rtl/bp_cfg_core_picker.sv
// Lowest set mask bit at or above from_i; purely combinational, no backpressure.
// from_i is one bit wider than idx_o so "past the last core" is representable.
module bp_cfg_core_picker #(
  parameter int num_core_p  = 16,
  parameter int idx_width_p = 4
) (
  input  logic [num_core_p-1:0]  mask_i,
  input  logic [idx_width_p:0]   from_i,
  output logic                   found_o,
  output logic [idx_width_p-1:0] idx_o
);

  // Descending scan so the lowest qualifying index is the last assignment.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = num_core_p - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(from_i))) begin
        found_o = 1'b1;
        idx_o   = idx_width_p'(i);
      end
    end
  end

endmodule

// File: rtl/bp_cfg_stream_loader.sv
// Streams freeze / table / unfreeze cfg writes to each masked core (or one broadcast pass).
// First beat one cycle after start; each beat holds until cfg_ready_i, no bubbles between beats.
module bp_cfg_stream_loader
  import bp_cfg_stream_loader_pkg::*;
#(
  parameter int num_core_p       = 16,
  parameter int num_regs_p       = 8,
  parameter int cfg_core_width_p = cfg_core_width_gp,
  parameter int cfg_addr_width_p = cfg_addr_width_gp,
  parameter int cfg_data_width_p = cfg_data_width_gp,
  parameter logic [cfg_addr_width_p-1:0] reg_base_addr_p = 16'h0010,
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p   = 16'h0002
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   start_i,
  input  logic                                   bcast_i,
  input  logic [num_core_p-1:0]                  core_mask_i,
  input  logic [num_regs_p*cfg_data_width_p-1:0] table_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   cfg_v_o,
  input  logic                                   cfg_ready_i,
  output logic [cfg_core_width_p-1:0]            cfg_core_o,
  output logic [cfg_addr_width_p-1:0]            cfg_addr_o,
  output logic [cfg_data_width_p-1:0]            cfg_data_o
);

  localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam int reg_w_lp  = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;

  bp_cfg_loader_state_e state_q, state_d;
  logic [core_w_lp-1:0] core_q, core_d;
  logic [reg_w_lp-1:0]  reg_q, reg_d;
  logic                 have_q, have_d;
  logic                 done_q, done_d;
  logic                 bcast_q;
  logic [num_core_p-1:0]                  mask_q;
  logic [num_regs_p*cfg_data_width_p-1:0] table_q;

  logic                  idle_like;
  logic                  start_acc;
  logic [num_core_p-1:0] pick_mask;
  logic [core_w_lp:0]    pick_from;
  logic                  pick_found;
  logic [core_w_lp-1:0]  pick_idx;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_acc = start_i && idle_like;
  assign busy_o    = !idle_like;
  assign done_o    = done_q;

  // One search serves both the first core (live mask from 0) and the next core (latched mask above current).
  assign pick_mask = idle_like ? core_mask_i : mask_q;
  assign pick_from = idle_like ? '0 : ((core_w_lp+1)'(core_q) + (core_w_lp+1)'(1));

  bp_cfg_core_picker #(
    .num_core_p  (num_core_p),
    .idx_width_p (core_w_lp)
  ) u_picker (
    .mask_i  (pick_mask),
    .from_i  (pick_from),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    core_d     = core_q;
    reg_d      = reg_q;
    have_d     = have_q;
    done_d     = done_q;
    cfg_v_o    = 1'b0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          state_d = S_FREEZE;
          done_d  = 1'b0;
          core_d  = pick_idx;
          reg_d   = '0;
          have_d  = bcast_i || pick_found;
        end
      end
      S_FREEZE: begin
        // Empty mask without broadcast: one busy cycle, no beats.
        if (!have_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cfg_v_o    = 1'b1;
          cfg_addr_o = freeze_addr_p;
          cfg_data_o = cfg_data_width_p'(cfg_freeze_data_gp);
          if (cfg_ready_i) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = reg_base_addr_p + cfg_addr_width_p'(reg_q);
        cfg_data_o = table_q[int'(reg_q)*cfg_data_width_p +: cfg_data_width_p];
        if (cfg_ready_i) begin
          if (reg_q == reg_w_lp'(num_regs_p - 1)) begin
            state_d = S_UNFREEZE;
            reg_d   = '0;
          end else begin
            reg_d = reg_q + reg_w_lp'(1);
          end
        end
      end
      S_UNFREEZE: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = freeze_addr_p;
        cfg_data_o = cfg_data_width_p'(cfg_unfreeze_data_gp);
        if (cfg_ready_i) begin
          if (!bcast_q && pick_found) begin
            state_d = S_FREEZE;
            core_d  = pick_idx;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_core_o = !cfg_v_o ? '0 : (bcast_q ? '1 : cfg_core_width_p'(core_q));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      core_q  <= '0;
      reg_q   <= '0;
      have_q  <= 1'b0;
      done_q  <= 1'b0;
      bcast_q <= 1'b0;
      mask_q  <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      reg_q   <= reg_d;
      have_q  <= have_d;
      done_q  <= done_d;
      if (start_acc) begin
        bcast_q <= bcast_i;
        mask_q  <= core_mask_i;
        table_q <= table_i;
      end
    end
  end

endmodule

// File: tb/tb_bp_cfg_stream_loader.sv
// Directed bench for the cfg stream loader: beat order, timing, stalls, ignored start, reset abort.
module tb_bp_cfg_stream_loader;
  import bp_cfg_stream_loader_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, bcast, cfg_ready;
  logic [15:0]  mask;
  logic [255:0] tbl;
  logic         busy, done, cfg_v;
  logic [7:0]   cfg_core;
  logic [15:0]  cfg_addr;
  logic [31:0]  cfg_data;

  logic         start1, bcast1, ready1;
  logic [15:0]  mask1;
  logic [31:0]  tbl1;
  logic         busy1, done1, v1;
  logic [7:0]   core1;
  logic [15:0]  addr1;
  logic [31:0]  data1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc, first_v_cyc, last_beat_cyc, done_cyc;
  bit rnd_mode = 1'b0;
  bit prev_stall = 1'b0;
  bit done_prev = 1'b0;
  bp_cfg_beat_s prev_beat;
  bp_cfg_beat_s beats_q[$];
  bp_cfg_beat_s beats1_q[$];
  bp_cfg_beat_s exp_q[$];

  always #5 clk = ~clk;

  bp_cfg_stream_loader dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .bcast_i(bcast),
    .core_mask_i(mask), .table_i(tbl), .busy_o(busy), .done_o(done),
    .cfg_v_o(cfg_v), .cfg_ready_i(cfg_ready), .cfg_core_o(cfg_core),
    .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data)
  );

  bp_cfg_stream_loader #(.num_regs_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start1), .bcast_i(bcast1),
    .core_mask_i(mask1), .table_i(tbl1), .busy_o(busy1), .done_o(done1),
    .cfg_v_o(v1), .cfg_ready_i(ready1), .cfg_core_o(core1),
    .cfg_addr_o(addr1), .cfg_data_o(data1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tbl(input logic [31:0] base);
    for (int k = 0; k < 8; k++) tbl[k*32 +: 32] = base + 32'(k);
  endtask

  // Reference beat list built straight from the intended protocol.
  task automatic build_exp(input logic [15:0] m, input logic b, input logic [31:0] base);
    bp_cfg_beat_s bt;
    logic [7:0] id;
    exp_q.delete();
    for (int c = 0; c < 16; c++) begin
      if (b ? (c == 0) : m[c]) begin
        id = b ? 8'hFF : 8'(c);
        bt = '{core: id, addr: 16'h0002, data: 32'd1};
        exp_q.push_back(bt);
        for (int k = 0; k < 8; k++) begin
          bt = '{core: id, addr: 16'h0010 + 16'(k), data: base + 32'(k)};
          exp_q.push_back(bt);
        end
        bt = '{core: id, addr: 16'h0002, data: 32'd0};
        exp_q.push_back(bt);
      end
    end
  endtask

  initial begin
    cfg_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cfg_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Beat collector and bus-discipline checks, sampled mid-cycle.
  always @(negedge clk) begin
    bp_cfg_beat_s cur;
    bp_cfg_beat_s c1;
    cyc++;
    cur = '{core: cfg_core, addr: cfg_addr, data: cfg_data};
    c1  = '{core: core1, addr: addr1, data: data1};
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) start_cyc = cyc;
      if (prev_stall) begin
        check_eq("stall_v", 64'(cfg_v), 64'd1);
        check_eq("stall_beat", 64'(cur), 64'(prev_beat));
      end
      if (!cfg_v) check_eq("idle_zero", 64'(cur), 64'd0);
      if (cfg_v && first_v_cyc < 0) first_v_cyc = cyc;
      if (cfg_v && cfg_ready) begin
        beats_q.push_back(cur);
        last_beat_cyc = cyc;
      end
      if (done && !done_prev) done_cyc = cyc;
      prev_stall = cfg_v && !cfg_ready;
      prev_beat  = cur;
      if (v1 && ready1) beats1_q.push_back(c1);
    end
    done_prev = done;
  end

  task automatic run_seq(input string tag, input logic [15:0] m, input logic b,
                         input logic [31:0] base, input bit rnd, input bit inject);
    int n;
    build_exp(m, b, base);
    mask = m;
    bcast = b;
    set_tbl(base);
    rnd_mode = rnd;
    beats_q.delete();
    start_cyc = -1; first_v_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_done_clr"}, 64'(done), 64'd0);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      if (inject && n == 4) begin
        mask = 16'hFFFF;
        bcast = 1'b1;
        set_tbl(32'h55);
        start = 1'b1;
      end
      if (inject && n == 5) start = 1'b0;
    end
    check_eq({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    tick();
    rnd_mode = 1'b0;
    check_eq({tag, "_end_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_end_done"}, 64'(done), 64'd1);
    check_eq({tag, "_end_v"}, 64'(cfg_v), 64'd0);
    check_eq({tag, "_nbeats"}, 64'(beats_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats_q.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), 64'(beats_q[i]), 64'(exp_q[i]));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_done_lat"}, 64'(done_cyc - start_cyc), 64'd2);
    end else begin
      check_eq({tag, "_first_lat"}, 64'(first_v_cyc - start_cyc), 64'd1);
      check_eq({tag, "_done_after_last"}, 64'(done_cyc - last_beat_cyc), 64'd1);
    end
  endtask

  initial begin
    int n;
    bp_cfg_beat_s exp1[3];
    reset_n = 1'b0;
    start = 1'b0; bcast = 1'b0; mask = '0; tbl = '0;
    start1 = 1'b0; bcast1 = 1'b0; mask1 = '0; tbl1 = '0; ready1 = 1'b1;
    #3;
    check_eq("rst_outputs", 64'({busy, done, cfg_v, cfg_core, cfg_addr, cfg_data}), 64'd0);
    check_eq("rst_outputs1", 64'({busy1, done1, v1, core1, addr1, data1}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_seq("m5", 16'h0005, 1'b0, 32'hA0, 1'b0, 1'b0);
    run_seq("m5rnd", 16'h0005, 1'b0, 32'hA0, 1'b1, 1'b0);
    run_seq("bcast", 16'h0000, 1'b1, 32'hB0, 1'b0, 1'b0);
    run_seq("empty", 16'h0000, 1'b0, 32'hC0, 1'b0, 1'b0);
    run_seq("inject", 16'h0005, 1'b0, 32'hA0, 1'b0, 1'b1);

    // Abort in the third table write of core 2, then a clean rerun.
    mask = 16'h0005; bcast = 1'b0; set_tbl(32'hA0);
    beats_q.delete();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (beats_q.size() < 13 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("rstmid_wait", 64'(beats_q.size()), 64'd13);
    tick();
    check_eq("rstmid_pre", 64'({cfg_v, cfg_core, cfg_addr, cfg_data}),
             64'({1'b1, 8'h02, 16'h0012, 32'hA2}));
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_async", 64'({busy, done, cfg_v, cfg_core, cfg_addr, cfg_data}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_eq("rstmid_done", 64'(done), 64'd0);
    run_seq("fresh", 16'h0005, 1'b0, 32'hA0, 1'b0, 1'b0);

    // Single-register instance: core 15 only, then an immediate restart.
    exp1[0] = '{core: 8'h0F, addr: 16'h0002, data: 32'd1};
    exp1[1] = '{core: 8'h0F, addr: 16'h0010, data: 32'h1234_5678};
    exp1[2] = '{core: 8'h0F, addr: 16'h0002, data: 32'd0};
    mask1 = 16'h8000;
    tbl1 = 32'h1234_5678;
    beats1_q.delete();
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("r1_timeout", 64'(n < 200), 64'd1);
    check_eq("r1_nbeats_first", 64'(beats1_q.size()), 64'd3);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("r1_b2b_busy", 64'(busy1), 64'd1);
    check_eq("r1_b2b_done", 64'(done1), 64'd0);
    n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("r1_timeout2", 64'(n < 200), 64'd1);
    tick();
    check_eq("r1_nbeats", 64'(beats1_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < beats1_q.size(); i++)
      check_eq($sformatf("r1_beat%0d", i), 64'(beats1_q[i]), 64'(exp1[i % 3]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
